// File: rtl/spi_cfg_slave_p.sv
// spi_cfg_slave_p
//   SPI configuration slave. SPI pins are sampled on clk_40MHz; frames are
//   decoded into a bank of configuration registers. A completed write pulses
//   the matching one-hot command strobe. A read returns SYNC followed by the
//   addressed register. Frames cut short by spi_cs rising are counted.
//
// Ports
//   clk_40MHz  system clock, SPI pins sampled on its rising edge
//   rst        asynchronous active-high reset
//   spi_cs     frame select, active low
//   spi_sdi    serial data in, MSB first
//   spi_sdo    serial data out (registered)
//   reg_q      register bank, reg i at [i*DATA_W +: DATA_W]
//   cmd_stb    one-cycle one-hot strobe per written index
//   wr_idx     index of last completed write
//   wr_data    data of last completed write
//   frame_err  one-cycle pulse on an aborted frame
//   err_cnt    saturating abort count
//
// state  | meaning
// S_IDLE | waiting for a fresh cs falling edge; samples the start bit (k=0)
// S_HDR  | samples R/W (k=1)
// S_IDX  | shifts in the index, drives SYNC on reads
// S_PAD  | pad bit; loads the read word
// S_DATA | shifts in data, shifts out the read word
// S_DONE | frame complete, waiting for cs high
// S_SKIP | rejected frame, waiting for cs high (silent)
module spi_cfg_slave_p #(
  parameter int              IDX_W  = 3,
  parameter int              DATA_W = 8,
  parameter int              NREG   = 8,
  parameter logic [IDX_W:0]  SYNC   = 4'b1001,
  parameter int              ERR_W  = 8
) (
  input  logic                   clk_40MHz,
  input  logic                   rst,
  input  logic                   spi_cs,
  input  logic                   spi_sdi,
  output logic                   spi_sdo,
  output logic [NREG*DATA_W-1:0] reg_q,
  output logic [NREG-1:0]        cmd_stb,
  output logic [IDX_W-1:0]       wr_idx,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   frame_err,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int MAX_W = (DATA_W > IDX_W) ? DATA_W : IDX_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_IDX, S_PAD, S_DATA, S_DONE, S_SKIP
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              cs_q;
  logic              rw_q;
  logic [IDX_W-1:0]  idx_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] rd_sr;
  logic [DATA_W-1:0] regs [NREG];

  logic              sdo_nxt, latch_rw, shift_idx, shift_data, load_rd;
  logic              commit, abort, sync_bit;
  logic [DATA_W-1:0] rd_word, wdata_nxt;

  for (genvar g = 0; g < NREG; g++) begin : g_regq
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  // Indices at or above NREG match no register and read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NREG; i++)
      if (idx_sr == IDX_W'(i)) rd_word = regs[i];
  end

  always_comb begin
    sync_bit = 1'b0;
    for (int i = 0; i <= IDX_W; i++)
      if (cnt == CNT_W'(i)) sync_bit = SYNC[i];
  end

  assign wdata_nxt = DATA_W'({data_sr, spi_sdi});

  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // spi_sdo for cycle k is decided on the edge that samples cycle k-1.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sdo_nxt    = 1'b0;
    latch_rw   = 1'b0;
    shift_idx  = 1'b0;
    shift_data = 1'b0;
    load_rd    = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        // cs_q is cleared by reset, so cs held low through reset goes to SKIP.
        if (!spi_cs) state_nxt = (cs_q && spi_sdi) ? S_HDR : S_SKIP;
      end
      S_HDR: begin
        if (spi_cs) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          latch_rw  = 1'b1;
          sdo_nxt   = spi_sdi & SYNC[IDX_W];
          cnt_nxt   = CNT_W'(IDX_W - 1);
          state_nxt = S_IDX;
        end
      end
      S_IDX: begin
        if (spi_cs) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          shift_idx = 1'b1;
          sdo_nxt   = rw_q & sync_bit;
          if (cnt == '0) state_nxt = S_PAD;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      S_PAD: begin
        if (spi_cs) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          load_rd   = 1'b1;
          sdo_nxt   = rw_q & rd_word[DATA_W-1];
          cnt_nxt   = CNT_W'(DATA_W - 1);
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (spi_cs) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          shift_data = 1'b1;
          if (cnt == '0) begin
            commit    = ~rw_q;
            state_nxt = S_DONE;
          end else begin
            sdo_nxt = rw_q & rd_sr[DATA_W-1];
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      S_DONE, S_SKIP: begin
        if (spi_cs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_40MHz or posedge rst) begin
    if (rst) begin
      cs_q      <= 1'b0;
      rw_q      <= 1'b0;
      idx_sr    <= '0;
      data_sr   <= '0;
      rd_sr     <= '0;
      spi_sdo   <= 1'b0;
      cmd_stb   <= '0;
      wr_idx    <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      cs_q      <= spi_cs;
      spi_sdo   <= sdo_nxt;
      frame_err <= abort;
      if (latch_rw)   rw_q    <= spi_sdi;
      if (shift_idx)  idx_sr  <= IDX_W'({idx_sr, spi_sdi});
      if (shift_data) data_sr <= wdata_nxt;
      if (load_rd)    rd_sr   <= DATA_W'({rd_word, 1'b0});
      else if (shift_data) rd_sr <= DATA_W'({rd_sr, 1'b0});
      for (int i = 0; i < NREG; i++) begin
        cmd_stb[i] <= commit && (idx_sr == IDX_W'(i));
        if (commit && (idx_sr == IDX_W'(i))) regs[i] <= wdata_nxt;
      end
      if (commit) begin
        wr_idx  <= idx_sr;
        wr_data <= wdata_nxt;
      end
      if (abort && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cfg_slave_p.sv
`timescale 1ns/1ps
module tb_spi_cfg_slave_p;

  localparam int IDX_W = 3, DATA_W = 8, NREG = 8, ERR_W = 8;

  logic                   clk_40MHz = 1'b0;
  logic                   rst = 1'b1;
  logic                   spi_cs = 1'b1;
  logic                   spi_sdi = 1'b0;
  logic                   spi_sdo;
  logic [NREG*DATA_W-1:0] reg_q;
  logic [NREG-1:0]        cmd_stb;
  logic [IDX_W-1:0]       wr_idx;
  logic [DATA_W-1:0]      wr_data;
  logic                   frame_err;
  logic [ERR_W-1:0]       err_cnt;

  spi_cfg_slave_p #(.IDX_W(IDX_W), .DATA_W(DATA_W), .NREG(NREG),
                    .SYNC(4'b1001), .ERR_W(ERR_W)) dut (
    .clk_40MHz(clk_40MHz), .rst(rst), .spi_cs(spi_cs), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .reg_q(reg_q), .cmd_stb(cmd_stb), .wr_idx(wr_idx),
    .wr_data(wr_data), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #12.5 clk_40MHz = ~clk_40MHz;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [2:0] idx; logic [7:0] data; } wr_t;
  wr_t        exp_wr[$];
  int         abort_q[$];
  logic [7:0] mdl [NREG];
  int         exp_err_cnt = 0;
  wr_t        mon_e;
  int         cyc = 0;
  bit         track7 = 1'b0;
  int         stb7_cnt = 0;
  int         last_stb7 = -1;

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i*8 +: 8] = mdl[i];
    return v;
  endfunction

  always @(posedge clk_40MHz) cyc++;

  // Scoreboard side: pop expectations when the DUT strobes or flags an abort.
  always @(negedge clk_40MHz) begin
    if (!rst) begin
      if (cmd_stb != '0) begin
        if (exp_wr.size() == 0) begin
          check("stb_unexpected", 64'(cmd_stb), 64'd0);
        end else begin
          mon_e = exp_wr.pop_front();
          check("cmd_stb", 64'(cmd_stb), 64'd1 << mon_e.idx);
          check("wr_idx", 64'(wr_idx), 64'(mon_e.idx));
          check("wr_data", 64'(wr_data), 64'(mon_e.data));
          mdl[mon_e.idx] = mon_e.data;
          check("reg_q_commit", reg_q, model_vec());
          if (track7 && mon_e.idx == 3'd7) begin
            if (last_stb7 >= 0) check("stb7_gap", 64'(cyc - last_stb7), 64'd17);
            last_stb7 = cyc;
            stb7_cnt++;
          end
        end
      end
      if (frame_err) begin
        if (abort_q.size() == 0) begin
          check("err_unexpected", 64'd1, 64'd0);
        end else begin
          void'(abort_q.pop_front());
          if (exp_err_cnt < 255) exp_err_cnt++;
          check("err_cnt_pulse", 64'(err_cnt), 64'(exp_err_cnt));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_40MHz);
      spi_cs  = 1'b1;
      spi_sdi = 1'b0;
    end
  endtask

  // One frame: cs low for 'low' cycles, then a single cs-high cycle.
  task automatic frame(input bit start, input bit rw, input logic [2:0] idx,
                       input logic [7:0] data, input int low);
    logic [15:0] bits;
    logic [15:0] exp_sdo;
    wr_t w;
    bits    = {start, rw, idx, 1'b0, data, 2'b00};
    exp_sdo = '0;
    if (start && rw) exp_sdo = {2'b00, 4'b1001, mdl[idx], 2'b00};
    if (start && !rw && low >= 14) begin
      w.idx  = idx;
      w.data = data;
      exp_wr.push_back(w);
    end
    for (int k = 0; k < low; k++) begin
      @(negedge clk_40MHz);
      if (k < 16) check($sformatf("sdo_k%0d", k), 64'(spi_sdo), 64'(exp_sdo[15-k]));
      spi_cs  = 1'b0;
      spi_sdi = (k < 16) ? bits[15-k] : 1'b0;
    end
    @(negedge clk_40MHz);
    if (low >= 16) check("sdo_gap", 64'(spi_sdo), 64'd0);
    spi_cs  = 1'b1;
    spi_sdi = 1'b0;
    if (start && low >= 1 && low < 14) abort_q.push_back(1);
  endtask

  logic [15:0] rbits;
  logic [7:0]  last7;
  logic [63:0] exp_bank;

  initial begin
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    repeat (3) @(negedge clk_40MHz);
    check("rst_reg_q", reg_q, 64'd0);
    check("rst_cmd_stb", 64'(cmd_stb), 64'd0);
    check("rst_wr_idx", 64'(wr_idx), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_sdo", 64'(spi_sdo), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    idle(2);

    // basic write then read-back
    frame(1'b1, 1'b0, 3'd0, 8'hC0, 16);
    check("wr0_reg_q", reg_q, 64'h0000_0000_0000_00C0);
    frame(1'b1, 1'b1, 3'd0, 8'h00, 16);
    check("rd0_reg_q", reg_q, 64'h0000_0000_0000_00C0);

    // back-to-back writes to idx 7
    track7 = 1'b1;
    last7  = '0;
    for (int i = 0; i < 16; i++) begin
      last7 = 8'($urandom_range(0, 255));
      frame(1'b1, 1'b0, 3'd7, last7, 16);
    end
    idle(1);
    track7 = 1'b0;
    check("b2b_count", 64'(stb7_cnt), 64'd16);
    check("b2b_reg7", 64'(reg_q[63:56]), 64'(last7));
    frame(1'b1, 1'b1, 3'd7, 8'h00, 16);
    exp_bank = {last7, 48'd0, 8'hC0};

    // aborted write, then a good one
    frame(1'b1, 1'b0, 3'd3, 8'h5A, 10);
    idle(3);
    check("abort_reg_q", reg_q, exp_bank);
    check("abort_err_cnt", 64'(err_cnt), 64'd1);
    frame(1'b1, 1'b0, 3'd3, 8'h5A, 16);
    idle(1);
    exp_bank[31:24] = 8'h5A;
    check("post_abort_reg_q", reg_q, exp_bank);

    // boundaries: read cut one bit short aborts, write of exactly L cycles commits
    frame(1'b1, 1'b1, 3'd5, 8'h00, 13);
    idle(2);
    check("short_rd_err_cnt", 64'(err_cnt), 64'd2);
    frame(1'b1, 1'b0, 3'd4, 8'h3C, 14);
    idle(1);
    exp_bank[39:32] = 8'h3C;
    check("min_wr_reg_q", reg_q, exp_bank);

    // start bit 0 frames are ignored silently
    frame(1'b0, 1'b0, 3'd1, 8'hAA, 16);
    frame(1'b0, 1'b1, 3'd0, 8'h00, 16);
    idle(2);
    check("skip_reg_q", reg_q, exp_bank);
    check("skip_err_cnt", 64'(err_cnt), 64'd2);

    // reset in the middle of a write to idx 2
    rbits = {1'b1, 1'b0, 3'd2, 1'b0, 8'hFF, 2'b00};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_40MHz);
      spi_cs  = 1'b0;
      spi_sdi = rbits[15-k];
    end
    @(negedge clk_40MHz);
    rst = 1'b1;
    #1;
    check("mid_rst_reg_q", reg_q, 64'd0);
    check("mid_rst_cmd_stb", 64'(cmd_stb), 64'd0);
    check("mid_rst_wr_idx", 64'(wr_idx), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data), 64'd0);
    check("mid_rst_sdo", 64'(spi_sdo), 64'd0);
    check("mid_rst_frame_err", 64'(frame_err), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    exp_err_cnt = 0;
    @(negedge clk_40MHz);
    rst = 1'b0;
    // cs still low through reset release: a valid-looking frame must be skipped
    rbits = {1'b1, 1'b0, 3'd6, 1'b0, 8'h77, 2'b00};
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_40MHz);
      check($sformatf("held_cs_sdo_k%0d", k), 64'(spi_sdo), 64'd0);
      spi_cs  = 1'b0;
      spi_sdi = rbits[15-k];
    end
    idle(2);
    check("held_cs_reg_q", reg_q, 64'd0);
    check("held_cs_err_cnt", 64'(err_cnt), 64'd0);
    frame(1'b1, 1'b0, 3'd2, 8'h81, 16);
    idle(2);
    check("post_rst_reg_q", reg_q, 64'h0000_0000_0081_0000);
    check("post_rst_err_cnt", 64'(err_cnt), 64'd0);

    idle(3);
    check("sb_wr_left", 64'(exp_wr.size()), 64'd0);
    check("sb_abort_left", 64'(abort_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
